// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regs
// Summary  : I2C target with a bank of 8-bit registers behind an
//            auto-incrementing, persistent register pointer.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_regs #(
  parameter logic [6:0] DEVICE_ADDR = 7'h11,
  parameter int         NUM_REGS    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_busy,
  output logic       o_wr_valid,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data
);

  localparam int PTR_W = $clog2(NUM_REGS);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_WAIT_STOP = 4'd9
  } state_t;

  logic [1:0]       r_scl_sync;
  logic [1:0]       r_sda_sync;
  logic             r_scl_d;
  logic             r_sda_d;
  logic             w_scl;
  logic             w_sda;
  logic             w_scl_rise;
  logic             w_scl_fall;
  logic             w_start;
  logic             w_stop;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_mack;
  logic             w_mack_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] w_ptr_inc;
  logic             r_sda_oe;
  logic             w_oe_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_wr_en;
  logic [7:0]       w_ptr_ext;
  logic [7:0]       w_rd_cur;
  logic [7:0]       w_rd_nxt;

  logic             r_wr_valid;
  logic [7:0]       r_wr_addr;
  logic [7:0]       r_wr_data;
  logic [7:0]       r_regs [NUM_REGS];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // START/STOP need SCL high on both samples, so they never coincide with an SCL edge.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_ptr_inc  = r_ptr + PTR_W'(1);
  assign w_rd_cur   = r_regs[r_ptr];
  assign w_rd_nxt   = r_regs[w_ptr_inc];

  always_comb begin
    w_ptr_ext             = 8'h00;
    w_ptr_ext[PTR_W-1:0]  = r_ptr;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_mack_nxt  = r_mack;
    w_ptr_nxt   = r_ptr;
    w_oe_nxt    = r_sda_oe;
    w_busy_nxt  = r_busy;
    w_wr_en     = 1'b0;

    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (w_scl_rise && r_cnt != 4'd8) begin
            w_shift_nxt = {r_shift[6:0], w_sda};
            w_cnt_nxt   = r_cnt + 4'd1;
          end else if (w_scl_fall && r_cnt == 4'd8) begin
            w_cnt_nxt = 4'd0;
            if (r_state == S_ADDR) begin
              if (r_shift[7:1] == DEVICE_ADDR) begin
                w_state_nxt = S_ADDR_ACK;
                w_oe_nxt    = 1'b1;
                w_busy_nxt  = 1'b1;
              end else begin
                w_state_nxt = S_WAIT_STOP;
                w_busy_nxt  = 1'b0;
              end
            end else if (r_state == S_PTR) begin
              w_ptr_nxt   = r_shift[PTR_W-1:0];
              w_state_nxt = S_PTR_ACK;
              w_oe_nxt    = 1'b1;
            end else begin
              w_wr_en     = 1'b1;
              w_ptr_nxt   = w_ptr_inc;
              w_state_nxt = S_WDATA_ACK;
              w_oe_nxt    = 1'b1;
            end
          end
        end

        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 4'd0;
            w_oe_nxt  = 1'b0;
            // R/W bit is still in r_shift[0]; a read drives its MSB on this same edge.
            if (r_state == S_ADDR_ACK && r_shift[0]) begin
              w_state_nxt = S_RDATA;
              w_oe_nxt    = ~w_rd_cur[7];
              w_shift_nxt = {w_rd_cur[6:0], 1'b0};
            end else if (r_state == S_ADDR_ACK) begin
              w_state_nxt = S_PTR;
            end else begin
              w_state_nxt = S_WDATA;
            end
          end
        end

        S_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = 4'd0;
              w_mack_nxt  = 1'b1;
              w_state_nxt = S_RDATA_ACK;
            end else begin
              w_oe_nxt    = ~r_shift[7];
              w_shift_nxt = {r_shift[6:0], 1'b0};
            end
          end
        end

        S_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_mack_nxt = w_sda;
          end else if (w_scl_fall) begin
            if (!r_mack) begin
              w_ptr_nxt   = w_ptr_inc;
              w_oe_nxt    = ~w_rd_nxt[7];
              w_shift_nxt = {w_rd_nxt[6:0], 1'b0};
              w_cnt_nxt   = 4'd0;
              w_state_nxt = S_RDATA;
            end else begin
              w_state_nxt = S_WAIT_STOP;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_shift    <= 8'h00;
      r_mack     <= 1'b1;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= 8'h00;
      r_wr_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_mack     <= w_mack_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sda_oe   <= w_oe_nxt;
      r_busy     <= w_busy_nxt;
      r_wr_valid <= w_wr_en;
      if (w_wr_en) begin
        r_wr_addr <= w_ptr_ext;
        r_wr_data <= r_shift;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 8'h00;
      end
    end else if (w_wr_en) begin
      r_regs[r_ptr] <= r_shift;
    end
  end

  assign o_sda_oe   = r_sda_oe;
  assign o_busy     = r_busy;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;

endmodule
`default_nettype wire
